reduce_seq: RTL and testbench

- Parametrised, multi-cycle bit-reduction unit: folds a WIDTH-bit operand CHUNK bits per cycle into a single-bit result.
- Selectable reduction op: AND, OR, XOR or ZERO-detect (NOR).
- Optional early termination when the accumulator reaches an absorbing value.
- Used by the ALU/branch path for wide zero-flag, parity and all-ones detection where a flat gate tree would break timing. Valid/ready handshake on both sides.

---
 rtl/reduce_seq_if.sv | 26 ++
 rtl/reduce_seq.sv | 129 ++++++++++++
 tb/tb_reduce_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/reduce_seq_if.sv
// Handshake bundle for reduce_seq: operand channel in, result channel out.
// No logic here; WIDTH and CW must match the reduce_seq instance.
// master drives operands and out_ready; slave is the reduction unit.
interface reduce_seq_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic             out_result;
  logic [CW-1:0]    out_cycles;

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_cycles
  );

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_result, out_cycles
  );
endinterface

// File: rtl/reduce_seq.sv
// Multi-cycle bit reduction (AND/OR/XOR/ZERO), CHUNK bits folded per cycle.
// Latency: NCHUNK fold edges after accept (fewer with EARLY_EXIT on absorbing acc).
// Backpressure: single operand in flight; result held until out_ready, in_ready only in IDLE.
module reduce_seq #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 0,
  parameter int CW         = $clog2((WIDTH + CHUNK - 1) / CHUNK + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  reduce_seq_if.slave  bus
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             acc_q, acc_d;
  logic             result_q, result_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic [PW-1:0]    pad_vec;
  logic [PW-1:0]    shifted;
  logic [CHUNK-1:0] chunk;
  logic             acc_fold;
  logic             absorbing;
  logic             last;

  // Select the current chunk (upper padding uses the op identity) and fold it into acc
  always_comb begin
    pad_vec              = {PW{op_q == OP_AND}};
    pad_vec[WIDTH-1:0]   = data_q;
    shifted              = pad_vec >> (CHUNK * int'(idx_q));
    chunk                = shifted[CHUNK-1:0];
    acc_fold             = acc_q;
    absorbing            = 1'b0;
    case (op_q)
      OP_AND: begin
        acc_fold  = acc_q & (&chunk);
        absorbing = ~acc_fold;
      end
      OP_XOR: begin
        acc_fold  = acc_q ^ (^chunk);
        absorbing = 1'b0;
      end
      default: begin
        // OR and ZERO both accumulate with OR; ZERO inverts at the end
        acc_fold  = acc_q | (|chunk);
        absorbing = acc_fold;
      end
    endcase
    last = (idx_q == CW'(NCHUNK - 1));
  end

  // Next-state and datapath updates for IDLE -> RUN -> DONE
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    op_d     = op_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    cycles_d = cycles_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          op_d    = bus.in_op;
          idx_d   = '0;
          acc_d   = (bus.in_op == OP_AND);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_fold;
        idx_d = idx_q + 1'b1;
        if (last || ((EARLY_EXIT != 0) && absorbing)) begin
          state_d  = DONE;
          result_d = (op_q == OP_ZERO) ? ~acc_fold : acc_fold;
          cycles_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operand in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      op_q     <= OP_AND;
      idx_q    <= '0;
      acc_q    <= 1'b0;
      result_q <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;
  assign bus.out_cycles = cycles_q;

endmodule

// File: tb/tb_reduce_seq.sv
// Directed bench for reduce_seq: three configurations share one stimulus path.
// sel picks which instance sees in_valid and whose outputs are observed.
// Expected results and fold counts are hand-computed per vector.
module tb_reduce_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic        out_ready;
  int          sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reduce_seq_if #(.WIDTH(32), .CW(4)) if0 ();
  reduce_seq_if #(.WIDTH(32), .CW(4)) if1 ();
  reduce_seq_if #(.WIDTH(30), .CW(4)) if2 ();

  reduce_seq #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(0)) u_base  (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  reduce_seq #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(1)) u_early (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  reduce_seq #(.WIDTH(30), .CHUNK(4), .EARLY_EXIT(0)) u_pad   (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  assign if0.in_valid  = in_valid && (sel == 0);
  assign if1.in_valid  = in_valid && (sel == 1);
  assign if2.in_valid  = in_valid && (sel == 2);
  assign if0.in_data   = in_data;
  assign if1.in_data   = in_data;
  assign if2.in_data   = in_data[29:0];
  assign if0.in_op     = in_op;
  assign if1.in_op     = in_op;
  assign if2.in_op     = in_op;
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;
  assign if2.out_ready = out_ready;

  logic       in_ready_o, out_valid_o, out_result_o;
  logic [3:0] out_cycles_o;

  assign in_ready_o   = (sel == 0) ? if0.in_ready   : (sel == 1) ? if1.in_ready   : if2.in_ready;
  assign out_valid_o  = (sel == 0) ? if0.out_valid  : (sel == 1) ? if1.out_valid  : if2.out_valid;
  assign out_result_o = (sel == 0) ? if0.out_result : (sel == 1) ? if1.out_result : if2.out_result;
  assign out_cycles_o = (sel == 0) ? if0.out_cycles : (sel == 1) ? if1.out_cycles : if2.out_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operand starting at a negedge; returns at a negedge with the unit idle.
  // bp=1: keep in_valid high with scrambled data and hold out_ready low for 5 cycles.
  task automatic run_op(input int s, input logic [31:0] d, input logic [1:0] op,
                        input logic exp_res, input int exp_cyc, input string tag, input bit bp);
    int  n;
    bit  got;
    sel       = s;
    in_data   = d;
    in_op     = op;
    in_valid  = 1'b1;
    out_ready = !bp;
    chk({tag, ".ready_before"}, 32'(in_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (bp) begin
      in_data = ~d;
      in_op   = op ^ 2'b10;
    end else begin
      in_valid = 1'b0;
    end
    n   = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      chk({tag, ".ready_busy"}, 32'(in_ready_o), 32'd0);
      @(posedge clk);
      n++;
      @(negedge clk);
      got = out_valid_o;
    end
    chk({tag, ".valid_seen"}, 32'(got), 32'd1);
    chk({tag, ".edges"}, 32'(n), 32'(exp_cyc));
    chk({tag, ".result"}, 32'(out_result_o), 32'(exp_res));
    chk({tag, ".cycles"}, 32'(out_cycles_o), 32'(exp_cyc));
    if (bp) begin
      repeat (5) begin
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".bp_valid"}, 32'(out_valid_o), 32'd1);
        chk({tag, ".bp_result"}, 32'(out_result_o), 32'(exp_res));
        chk({tag, ".bp_ready"}, 32'(in_ready_o), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".valid_drop"}, 32'(out_valid_o), 32'd0);
    chk({tag, ".ready_after"}, 32'(in_ready_o), 32'd1);
    chk({tag, ".result_kept"}, 32'(out_result_o), 32'(exp_res));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = 2'b00;
    out_ready = 1'b1;
    sel       = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset.in_ready", 32'(in_ready_o), 32'd1);
      chk("reset.out_valid", 32'(out_valid_o), 32'd0);
      chk("reset.out_result", 32'(out_result_o), 32'd0);
      chk("reset.out_cycles", 32'(out_cycles_o), 32'd0);
    end
    @(negedge clk);

    // Full-length folds, no early exit
    run_op(0, 32'hFFFF_FFFF, 2'b00, 1'b1, 8, "and_ones", 1'b0);
    run_op(0, 32'hFFFF_FFFE, 2'b00, 1'b0, 8, "and_lsb0", 1'b0);
    run_op(0, 32'h0000_0000, 2'b11, 1'b1, 8, "zero_zero", 1'b0);
    run_op(0, 32'h8000_0000, 2'b11, 1'b0, 8, "zero_msb", 1'b0);
    run_op(0, 32'h0001_0001, 2'b10, 1'b0, 8, "xor_even", 1'b0);

    // Early exit on absorbing accumulator
    run_op(1, 32'hFFFF_FFF0, 2'b00, 1'b0, 1, "ee_and", 1'b0);
    run_op(1, 32'h0100_0000, 2'b01, 1'b1, 7, "ee_or", 1'b0);
    run_op(1, 32'h0000_0001, 2'b10, 1'b1, 8, "ee_xor", 1'b0);

    // WIDTH=30: padded top chunk must not leak
    run_op(2, 32'h3FFF_FFFF, 2'b00, 1'b1, 8, "pad_and", 1'b0);
    run_op(2, 32'h2000_0000, 2'b11, 1'b0, 8, "pad_zero", 1'b0);

    // Backpressure with in_valid held and operand changing after accept
    run_op(0, 32'hFFFF_FFFF, 2'b00, 1'b1, 8, "bp_and", 1'b1);

    // Asynchronous reset in the middle of a fold
    sel      = 0;
    in_data  = 32'h0000_0000;
    in_op    = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mid.busy_before", 32'(in_ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_mid.out_result", 32'(out_result_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid.no_result", 32'(out_valid_o), 32'd0);
    run_op(0, 32'h0000_0000, 2'b01, 1'b0, 8, "post_rst_or", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
